// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write-side arbiter.
// The FSM state enum and the clog2-based width rules live here so the
// top level and the round-robin picker size their indices the same way.
package fifo_wr_arbiter_pkg;

    // Arbiter ownership state: nobody owns the FIFO, or one requester does.
    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Default configuration of the arbiter.
    localparam int NREQ_DEF     = 4;
    localparam int DSIZE_DEF    = 8;
    localparam int MAXBEATS_DEF = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must be able to hold the value maxbeats.
    function automatic int cnt_width(input int maxbeats);
        return (maxbeats > 0) ? $clog2(maxbeats + 1) : 1;
    endfunction

    // Widths for the default configuration.
    localparam int PTR_W_DEF = idx_width(NREQ_DEF);
    localparam int CNT_W_DEF = cnt_width(MAXBEATS_DEF);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Returns the first asserted request found when searching upward from
// rr_ptr, wrapping modulo NREQ, as both a one-hot vector and an index.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PTR_W = idx_width(NREQ_DEF)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  winner_oh,
    output logic [PTR_W-1:0] winner_idx,
    output logic             any_req
);

    logic found;

    // Walk the priority order (rr_ptr, rr_ptr+1, ...) and latch the first hit.
    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(rr_ptr) + k) % NREQ) == i)) begin
                    found        = 1'b1;
                    winner_oh[i] = 1'b1;
                    winner_idx   = PTR_W'(i);
                end
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-level write arbiter in front of an async FIFO write port.
// One requester at a time owns the FIFO for a whole packet; ownership ends
// on the accepted last beat or after MAXBEATS accepted beats (truncation).
// A single idle cycle always separates two packets, and the round-robin
// pointer advances past the previous owner on each release.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int DSIZE    = DSIZE_DEF,
    parameter int MAXBEATS = MAXBEATS_DEF
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    input  logic                  awfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  trunc
);

    localparam int PTR_W = idx_width(NREQ);
    localparam int CNT_W = cnt_width(MAXBEATS);

    // Registered control state
    arb_state_t       state_q,     state_d;
    logic [NREQ-1:0]  grant_q,     grant_d;
    logic [PTR_W-1:0] owner_idx_q, owner_idx_d;
    logic [PTR_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q,  beat_cnt_d;
    logic             trunc_q,     trunc_d;

    // Round-robin picker results
    logic [NREQ-1:0]  pick_oh;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;

    // Owner-side combinational terms
    logic             owner_valid;
    logic             owner_last;
    logic             beat_acc;
    logic [CNT_W-1:0] beat_cnt_inc;
    logic [PTR_W-1:0] rr_ptr_after;

    fifo_wr_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req        (req_valid),
        .rr_ptr     (rr_ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any_req    (pick_any)
    );

    // grant_q is all-zero outside OWN, so masking with it selects the owner's
    // flags and naturally yields zero while idle or held in reset.
    assign owner_valid = |(grant_q & req_valid);
    assign owner_last  = |(grant_q & req_last);

    // A beat moves only when the owner offers one and the FIFO has room;
    // awfull deliberately plays no part once a packet is under way.
    assign beat_acc     = (state_q == OWN) && owner_valid && !wfull;
    assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

    // Pointer value after releasing the current owner: owner + 1, wrapping.
    assign rr_ptr_after = (owner_idx_q == PTR_W'(NREQ - 1)) ? '0
                                                            : owner_idx_q + PTR_W'(1);

    // Handshake and write strobe toward the requesters and the FIFO.
    assign winc      = beat_acc;
    assign req_ready = (state_q == OWN && !wfull) ? (grant_q & req_valid) : '0;
    assign grant     = grant_q;
    assign trunc     = trunc_q;

    // Select the owner's data lane; only meaningful while winc is high.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                wdata = wdata | req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    // Next-state logic: grant in IDLE, count and release in OWN.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_idx_d = owner_idx_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        trunc_d     = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                // awfull stops new packets from starting, nothing else.
                if (pick_any && !awfull) begin
                    state_d     = OWN;
                    grant_d     = pick_oh;
                    owner_idx_d = pick_idx;
                    beat_cnt_d  = '0;
                end
            end
            OWN: begin
                // A stalled owner (valid low or FIFO full) just holds the grant.
                if (beat_acc) begin
                    if (owner_last || (beat_cnt_inc == CNT_W'(MAXBEATS))) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        rr_ptr_d   = rr_ptr_after;
                        beat_cnt_d = '0;
                        // Only a length-forced release counts as truncation;
                        // a last beat landing exactly on MAXBEATS is normal.
                        trunc_d    = !owner_last;
                    end else begin
                        beat_cnt_d = beat_cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_idx_q <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_idx_q <= owner_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            trunc_q     <= trunc_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DSIZE=8, MAXBEATS=16).
// Inputs change 1 time unit after a rising edge; outputs are checked on the
// following falling edge.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        wfull;
    logic        awfull;
    logic        winc;
    logic [7:0]  wdata;
    logic [3:0]  grant;
    logic        trunc;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arbiter #(
        .NREQ     (4),
        .DSIZE    (8),
        .MAXBEATS (16)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wfull     (wfull),
        .awfull    (awfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .trunc     (trunc)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge wclk);
    endtask

    task automatic adv();
        @(posedge wclk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] val);
        req_data[idx*8 +: 8] = val;
    endtask

    // Safety net against a hung simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_oh;

        // ---------- reset state, with a request pending ----------
        wrst_n    = 1'b0;
        req_valid = 4'b0001;
        req_data  = '0;
        req_last  = '0;
        wfull     = 1'b0;
        awfull    = 1'b0;
        sample();
        chk("rst_grant", 32'(grant), 'h0);
        chk("rst_winc", 32'(winc), 'h0);
        chk("rst_ready", 32'(req_ready), 'h0);
        chk("rst_trunc", 32'(trunc), 'h0);
        adv();
        wrst_n = 1'b1;

        // ---------- all four requesting 1-beat packets ----------
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int i = 0; i < 4; i++) set_data(i, 8'(8'h10 + i));
        sample();
        chk("rr_first_idle", 32'(grant), 'h0);
        adv();
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            sample();
            chk("rr_grant", 32'(grant), 32'(exp_oh));
            chk("rr_winc", 32'(winc), 'h1);
            chk("rr_wdata", 32'(wdata), 32'(8'h10 + (k % 4)));
            chk("rr_ready", 32'(req_ready), 32'(exp_oh));
            adv();
            if (k == 4) req_valid = 4'b0000;
            sample();
            chk("rr_bubble_grant", 32'(grant), 'h0);
            chk("rr_bubble_winc", 32'(winc), 'h0);
            adv();
        end
        req_last = '0;

        // ---------- requester 0, 3-beat packet, with an owner stall ----------
        req_valid = 4'b0001;
        set_data(0, 8'hA1);
        sample();
        chk("p3_idle", 32'(grant), 'h0);
        adv();
        sample();
        chk("p3_grant", 32'(grant), 'h1);
        chk("p3_winc0", 32'(winc), 'h1);
        chk("p3_wdata0", 32'(wdata), 'hA1);
        chk("p3_ready0", 32'(req_ready), 'h1);
        adv();
        req_valid = 4'b0000;
        for (int s = 0; s < 2; s++) begin
            sample();
            chk("stall_grant", 32'(grant), 'h1);
            chk("stall_winc", 32'(winc), 'h0);
            chk("stall_ready", 32'(req_ready), 'h0);
            adv();
        end
        req_valid = 4'b0001;
        set_data(0, 8'hA2);
        sample();
        chk("p3_winc1", 32'(winc), 'h1);
        chk("p3_wdata1", 32'(wdata), 'hA2);
        adv();
        set_data(0, 8'hA3);
        req_last = 4'b0001;
        sample();
        chk("p3_winc2", 32'(winc), 'h1);
        chk("p3_wdata2", 32'(wdata), 'hA3);
        adv();
        req_valid = '0;
        req_last  = '0;
        sample();
        chk("p3_release_grant", 32'(grant), 'h0);
        chk("p3_release_winc", 32'(winc), 'h0);
        adv();

        // ---------- wfull for 4 cycles mid-packet (requester 2) ----------
        req_valid = 4'b0100;
        set_data(2, 8'hB0);
        sample();
        adv();
        sample();
        chk("wf_grant", 32'(grant), 'h4);
        chk("wf_wdata0", 32'(wdata), 'hB0);
        chk("wf_winc0", 32'(winc), 'h1);
        adv();
        set_data(2, 8'hB1);
        sample();
        chk("wf_wdata1", 32'(wdata), 'hB1);
        chk("wf_winc1", 32'(winc), 'h1);
        adv();
        set_data(2, 8'hB2);
        wfull = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sample();
            chk("wf_full_winc", 32'(winc), 'h0);
            chk("wf_full_ready", 32'(req_ready), 'h0);
            chk("wf_full_grant", 32'(grant), 'h4);
            adv();
        end
        wfull = 1'b0;
        sample();
        chk("wf_wdata2", 32'(wdata), 'hB2);
        chk("wf_winc2", 32'(winc), 'h1);
        adv();
        set_data(2, 8'hB3);
        req_last = 4'b0100;
        sample();
        chk("wf_wdata3", 32'(wdata), 'hB3);
        chk("wf_winc3", 32'(winc), 'h1);
        adv();
        req_valid = '0;
        req_last  = '0;
        sample();
        chk("wf_release", 32'(grant), 'h0);
        adv();

        // ---------- awfull blocks new grants only ----------
        awfull    = 1'b1;
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        set_data(1, 8'hE1);
        for (int s = 0; s < 3; s++) begin
            sample();
            chk("af_block_grant", 32'(grant), 'h0);
            chk("af_block_winc", 32'(winc), 'h0);
            adv();
        end
        awfull = 1'b0;
        sample();
        chk("af_clear_same_cycle", 32'(grant), 'h0);
        adv();
        awfull = 1'b1;
        sample();
        chk("af_grant", 32'(grant), 'h2);
        chk("af_owned_winc", 32'(winc), 'h1);
        chk("af_owned_wdata", 32'(wdata), 'hE1);
        adv();
        req_valid = '0;
        req_last  = '0;
        awfull    = 1'b0;
        sample();
        chk("af_release", 32'(grant), 'h0);
        adv();

        // ---------- MAXBEATS truncation (req 3), req 0 waiting ----------
        req_valid = 4'b1001;
        req_last  = 4'b0001;
        set_data(0, 8'hD0);
        set_data(3, 8'hC0);
        sample();
        chk("mb_idle", 32'(grant), 'h0);
        adv();
        for (int k = 0; k < 16; k++) begin
            set_data(3, 8'(8'hC0 + k));
            sample();
            chk("mb_grant", 32'(grant), 'h8);
            chk("mb_winc", 32'(winc), 'h1);
            chk("mb_wdata", 32'(wdata), 32'(8'hC0 + k));
            chk("mb_ready", 32'(req_ready), 'h8);
            chk("mb_trunc_low", 32'(trunc), 'h0);
            adv();
        end
        set_data(3, 8'hD4);
        sample();
        chk("mb_release_grant", 32'(grant), 'h0);
        chk("mb_trunc_pulse", 32'(trunc), 'h1);
        chk("mb_release_winc", 32'(winc), 'h0);
        adv();
        sample();
        chk("mb_next_grant", 32'(grant), 'h1);
        chk("mb_trunc_gone", 32'(trunc), 'h0);
        chk("mb_next_wdata", 32'(wdata), 'hD0);
        adv();
        req_valid = '0;
        req_last  = '0;
        sample();
        chk("mb_next_release", 32'(grant), 'h0);
        chk("mb_next_trunc", 32'(trunc), 'h0);
        adv();

        // ---------- last beat coincides with MAXBEATS (req 1) ----------
        req_valid = 4'b0010;
        sample();
        adv();
        for (int k = 0; k < 16; k++) begin
            set_data(1, 8'(8'h60 + k));
            req_last = (k == 15) ? 4'b0010 : 4'b0000;
            sample();
            chk("ml_winc", 32'(winc), 'h1);
            chk("ml_wdata", 32'(wdata), 32'(8'h60 + k));
            adv();
        end
        req_valid = '0;
        req_last  = '0;
        sample();
        chk("ml_release_grant", 32'(grant), 'h0);
        chk("ml_no_trunc", 32'(trunc), 'h0);
        adv();

        // ---------- reset on beat 2 of a 5-beat packet ----------
        req_valid = 4'b0110;
        set_data(1, 8'hF1);
        set_data(2, 8'hF2);
        sample();
        adv();
        sample();
        chk("rm_grant", 32'(grant), 'h4);
        chk("rm_wdata0", 32'(wdata), 'hF2);
        adv();
        sample();
        chk("rm_winc1", 32'(winc), 'h1);
        adv();
        wrst_n = 1'b0;
        sample();
        chk("rm_rst_grant", 32'(grant), 'h0);
        chk("rm_rst_winc", 32'(winc), 'h0);
        chk("rm_rst_ready", 32'(req_ready), 'h0);
        chk("rm_rst_trunc", 32'(trunc), 'h0);
        adv();
        wrst_n = 1'b1;
        sample();
        chk("rm_post_idle", 32'(grant), 'h0);
        chk("rm_post_winc", 32'(winc), 'h0);
        adv();
        req_last = 4'b0010;
        sample();
        chk("rm_post_grant_lowest", 32'(grant), 'h2);
        chk("rm_post_wdata", 32'(wdata), 'hF1);
        adv();
        req_valid = '0;
        req_last  = '0;
        sample();
        chk("rm_post_release", 32'(grant), 'h0);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter DSIZE, default 8, data beat width.
REQ-003 Parameter MAXBEATS, default 16, max beats per packet before forced release.
REQ-004 wclk  input  1  write-domain clock, all logic rising-edge.
REQ-005 wrst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NREQ  per-requester beat valid.
REQ-007 req_data  input  NREQ*DSIZE  per-requester beat data, requester i at bits [i*DSIZE +: DSIZE].
REQ-008 req_last  input  NREQ  per-requester last-beat-of-packet flag.
REQ-009 req_ready  output  NREQ  per-requester beat accepted this cycle.
REQ-010 wfull  input  1  FIFO full flag, registered, write domain.
REQ-011 awfull  input  1  FIFO almost-full flag, registered, write domain.
REQ-012 winc  output  1  FIFO write enable.
REQ-013 wdata  output  DSIZE  FIFO write data.
REQ-014 grant  output  NREQ  one-hot current owner, all-zero when idle.
REQ-015 trunc  output  1  one-cycle pulse, packet force-released at MAXBEATS.

Function
REQ-016 FSM states IDLE and OWN; reset state IDLE.
REQ-017 IDLE: if any req_valid=1 and awfull=0, register winner into grant and go to OWN next cycle; else stay IDLE with grant=0.
REQ-018 Winner selection: round-robin, first requester with req_valid=1 searching from rr_ptr upward modulo NREQ.
REQ-019 rr_ptr (width clog2(NREQ)) resets to 0, updates on packet release to (owner index + 1) mod NREQ.
REQ-020 OWN: req_ready[owner] = req_valid[owner] & ~wfull, combinational from registered grant and wfull; all other req_ready=0.
REQ-021 winc = req_valid[owner] & ~wfull in OWN, 0 in IDLE; winc never asserted while wfull=1.
REQ-022 wdata = req_data slice of owner, combinational mux; value don't-care when winc=0.
REQ-023 awfull only blocks new grants; an owned packet continues until wfull.
REQ-024 Beat counter (width clog2(MAXBEATS+1)) clears on grant, increments per accepted beat.
REQ-025 Release: accepted beat with req_last=1, or accepted beat bringing count to MAXBEATS; go IDLE next cycle, grant=0 that cycle.
REQ-026 MAXBEATS release without req_last: trunc=1 on the cycle after the releasing beat; otherwise trunc=0.
REQ-027 Arbitration bubble: exactly one idle cycle between packets (release cycle+1 = IDLE, +2 = new OWN earliest).
REQ-028 Owner req_valid=0 in OWN: hold grant, no beat, no timeout.
REQ-029 Simultaneous req_last and count reaching MAXBEATS: normal release, trunc=0.
REQ-030 Requests arriving while OWN: ignored until IDLE; no preemption.

Reset
REQ-031 On wrst_n=0: state=IDLE, grant=0, rr_ptr=0, beat count=0, trunc=0.
REQ-032 Combinational outputs during reset: winc=0, req_ready=0.
REQ-033 Reset mid-packet: packet abandoned, no further winc; requester must resend after reset release.
REQ-034 Reset deassertion synchronised externally to wclk; block adds no synchroniser.

Structure
REQ-035 Shared package holds FSM state enum (IDLE, OWN) and clog2-based width constants.
REQ-036 One sub-module natural: rr_pick (combinational round-robin priority encoder: req vector, rr_ptr in, one-hot winner and index out).
REQ-037 Block instantiated alongside wptr_full; wfull/awfull connected directly, winc driven into it.

Verification
REQ-038 Single requester 0, 3-beat packet, wfull=0: grant=0001 one cycle after req_valid, winc high 3 cycles, wdata 0xA1,0xA2,0xA3, IDLE after last.
REQ-039 All 4 requesting 1-beat packets continuously: grant order 0,1,2,3,0, one IDLE bubble between each.
REQ-040 wfull=1 for 4 cycles mid-packet: winc=0 and req_ready=0 those cycles, no beat lost or duplicated, grant held.
REQ-041 awfull=1 in IDLE with requests pending: grant stays 0 until awfull=0, then grant next cycle.
REQ-042 MAXBEATS=16, 20-beat packet without req_last: 16 beats accepted, trunc pulse one cycle, next requester granted.
REQ-043 wrst_n asserted on beat 2 of 5: winc and grant 0 immediately, rr_ptr=0, first grant after reset to lowest valid index.
